icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped instruction cache between the fetcher and the memory controller.
- Hits return the 32-bit instruction one cycle after the request, with no memory traffic.
- Misses issue a single word read to the memory controller, fill the line and forward the word to the fetcher.
- A misbranch from the ROB aborts any outstanding miss, so the pipeline flush also covers this block.

Parameters:
- INDEX_BITS, 7, number of index bits; line count = 2**INDEX_BITS; each line holds one 32-bit word.
- ADDR_BITS, 18, significant byte-address bits (RAM/IO space 17:0).
- TAG_BITS, ADDR_BITS-2-INDEX_BITS, stored tag width (9 at defaults).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- rdy  in  1  global ready; when low all state and outputs freeze
- in_fetch_req  in  1  fetcher requests the instruction at in_fetch_pc (single-cycle pulse)
- in_fetch_pc  in  32  byte address, word aligned; bits [1:0] ignored
- out_fetch_valid  out  1  one-cycle pulse; out_fetch_instr is valid
- out_fetch_instr  out  32  returned instruction word
- out_busy  out  1  high while a miss is outstanding; fetcher must not request while high
- out_mem_req  out  1  level request for a 4-byte read, held until in_mem_valid
- out_mem_addr  out  32  word-aligned read address, stable while out_mem_req is high
- in_mem_valid  in  1  one-cycle pulse; in_mem_data holds the full word
- in_mem_data  in  32  little-endian assembled word from the memory controller
- in_misbranch  in  1  ROB flush; aborts the pending miss

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_BITS-1:INDEX_BITS+2]. Bits above ADDR_BITS-1 are ignored.
- Storage: per line, valid bit, tag and data. Valid bits clear on reset. Tag and data arrays are not reset.
- Reset (rst==0 at a clk edge), output values:
  - out_fetch_valid=0, out_fetch_instr=0, out_busy=0
  - out_mem_req=0, out_mem_addr=0
  - all valid bits 0, state=IDLE
  - Reset takes priority over rdy and every other input, including mid-miss.
- rdy==0: no register changes; outputs hold their previous values. in_mem_valid seen while rdy==0 is ignored (the memory controller is frozen by the same rdy).
- States: IDLE, MISS.
- IDLE, in_fetch_req=1, in_misbranch=0:
  - Hit (valid && tag match): next cycle out_fetch_valid=1 and out_fetch_instr=line data. Latency 1.
  - Miss: next cycle state=MISS, out_busy=1, out_mem_req=1, out_mem_addr={pc[31:2],2'b00}; out_fetch_valid=0.
- IDLE, in_fetch_req=1 and in_misbranch=1 in the same cycle: request dropped, no response.
- MISS, in_mem_valid=1, in_misbranch=0:
  - Write data, tag and valid=1 into the indexed line.
  - Next cycle: out_fetch_valid=1, out_fetch_instr=in_mem_data, out_mem_req=0, out_busy=0, state=IDLE.
  - Miss latency is 1 cycle after in_mem_valid.
- MISS, in_misbranch=1 (with or without in_mem_valid):
  - Next cycle: out_mem_req=0, out_busy=0, state=IDLE, no out_fetch_valid.
  - No line is written; a cancelled fill never pollutes the cache.
- in_fetch_req during MISS is a protocol violation and is ignored.
- out_fetch_valid is a one-cycle pulse; it is 0 in every cycle that has no response.
- Hit after fill: the same pc requested the cycle after the fill response hits (array write-before-read visible next cycle).
- Conflict: two pcs with equal index and different tag evict each other; the last fill wins.
- in_mem_valid while IDLE: ignored.

Test Plan:
- Reset then cold miss: rst low 2 cycles; req pc=0x0000_0100; mem returns 0x0000_0513 three cycles later -> out_mem_req=1 with addr 0x100 until the pulse; out_fetch_valid + 0x0000_0513 the next cycle; out_busy back to 0.
- Hit: re-request 0x100 -> out_fetch_valid exactly 1 cycle later with 0x0000_0513; out_mem_req stays 0.
- Conflict: fill 0x100 (data A) then 0x300 (same index 0x40, data B), then request 0x100 -> miss, out_mem_req=1 with addr 0x100.
- Misbranch abort: miss on 0x200; assert in_misbranch together with in_mem_valid -> no out_fetch_valid; a later request to 0x200 misses again.
- rdy freeze: during MISS drop rdy for 3 cycles while pulsing in_mem_valid -> pulse ignored, out_mem_req/out_mem_addr unchanged; after rdy returns, a valid pulse completes normally.
- Mid-miss reset: rst low during MISS -> next cycle out_mem_req=0, out_busy=0; previously cached 0x100 now misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller. Hits answer one cycle after the request; misses
// issue a single word read, fill the line and forward the word. A misbranch
// cancels an outstanding miss without writing the line.
module icache_direct #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_BITS  = 18,
    parameter int TAG_BITS   = ADDR_BITS - 2 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_pc,
    output logic        out_fetch_valid,
    output logic [31:0] out_fetch_instr,
    output logic        out_busy,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_valid,
    input  logic [31:0] in_mem_data,
    input  logic        in_misbranch
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [31:0]        data_q [LINES];

    logic               fetch_valid_q, fetch_valid_d;
    logic [31:0]        fetch_instr_q, fetch_instr_d;
    logic               busy_q, busy_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic [INDEX_BITS-1:0] req_idx_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic [INDEX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]   fill_tag_s;
    logic                  hit_s;
    logic                  fill_we_s;
    logic                  unused_pc_s;

    // The pending line is identified by the held read address, so no extra
    // index/tag registers are needed for the fill.
    assign req_idx_s   = in_fetch_pc[INDEX_BITS+1:2];
    assign req_tag_s   = in_fetch_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_idx_s  = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag_s  = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];
    assign hit_s       = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign unused_pc_s = ^in_fetch_pc[1:0];

    // Next-state, response and fill-enable logic for the IDLE/MISS controller.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        busy_d        = busy_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fill_we_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fetch_req && !in_misbranch) begin
                    if (hit_s) begin
                        fetch_valid_d = 1'b1;
                        fetch_instr_d = data_q[req_idx_s];
                    end else begin
                        state_d    = ST_MISS;
                        busy_d     = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {in_fetch_pc[31:2], 2'b00};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MISS: begin
                if (in_misbranch) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                end else if (in_mem_valid) begin
                    state_d             = ST_IDLE;
                    busy_d              = 1'b0;
                    mem_req_d           = 1'b0;
                    fetch_valid_d       = 1'b1;
                    fetch_instr_d       = in_mem_data;
                    valid_d[fill_idx_s] = 1'b1;
                    fill_we_s           = 1'b1;
                end else begin
                    state_d = ST_MISS;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Control and output registers: reset first, then frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= 32'h0000_0000;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
        end else if (rdy) begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    // Tag/data arrays are not reset; validity alone gates their contents.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill_we_s) begin
            tag_q[fill_idx_s]  <= fill_tag_s;
            data_q[fill_idx_s] <= in_mem_data;
        end
    end

    assign out_fetch_valid = fetch_valid_q;
    assign out_fetch_instr = fetch_instr_q;
    assign out_busy        = busy_q;
    assign out_mem_req     = mem_req_q;
    assign out_mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized
// fetches checked against a per-line reference model of the cache.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_fetch_req;
    logic [31:0] in_fetch_pc;
    logic        out_fetch_valid;
    logic [31:0] out_fetch_instr;
    logic        out_busy;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_valid;
    logic [31:0] in_mem_data;
    logic        in_misbranch;

    int checks   = 0;
    int failures = 0;

    // Reference model: which word address each line currently holds.
    bit          ref_valid [128];
    int          ref_tag   [128];
    logic [31:0] ref_data  [128];

    icache_direct dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetch_req(in_fetch_req), .in_fetch_pc(in_fetch_pc),
        .out_fetch_valid(out_fetch_valid), .out_fetch_instr(out_fetch_instr),
        .out_busy(out_busy), .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
        .in_mem_valid(in_mem_valid), .in_mem_data(in_mem_data),
        .in_misbranch(in_misbranch)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One complete fetch; hit/miss expectation comes from the model.
    task automatic run_fetch(input logic [31:0] pc, input int delay,
                             input logic [31:0] mdata, input bit abort);
        int idx;
        int tg;
        bit hit;
        idx = int'((pc >> 2) % 128);
        tg  = int'((pc % 32'd262144) / 32'd512);
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        in_fetch_req = 1'b1;
        in_fetch_pc  = pc;
        tick();
        in_fetch_req = 1'b0;
        in_fetch_pc  = $urandom;
        if (hit) begin
            chk("hit_valid", {31'd0, out_fetch_valid}, 32'd1);
            chk("hit_instr", out_fetch_instr, ref_data[idx]);
            chk("hit_no_memreq", {31'd0, out_mem_req}, 32'd0);
            chk("hit_not_busy", {31'd0, out_busy}, 32'd0);
        end else begin
            chk("miss_no_valid", {31'd0, out_fetch_valid}, 32'd0);
            chk("miss_memreq", {31'd0, out_mem_req}, 32'd1);
            chk("miss_addr", out_mem_addr, {pc[31:2], 2'b00});
            chk("miss_busy", {31'd0, out_busy}, 32'd1);
            for (int d = 0; d < delay; d++) begin
                tick();
                chk("miss_hold_req", {31'd0, out_mem_req}, 32'd1);
                chk("miss_hold_addr", out_mem_addr, {pc[31:2], 2'b00});
                chk("miss_wait_no_valid", {31'd0, out_fetch_valid}, 32'd0);
            end
            in_mem_valid = 1'b1;
            in_mem_data  = mdata;
            in_misbranch = abort;
            tick();
            in_mem_valid = 1'b0;
            in_misbranch = 1'b0;
            in_mem_data  = $urandom;
            chk("fill_memreq_drop", {31'd0, out_mem_req}, 32'd0);
            chk("fill_busy_drop", {31'd0, out_busy}, 32'd0);
            if (abort) begin
                chk("abort_no_valid", {31'd0, out_fetch_valid}, 32'd0);
            end else begin
                chk("fill_valid", {31'd0, out_fetch_valid}, 32'd1);
                chk("fill_instr", out_fetch_instr, mdata);
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
                ref_data[idx]  = mdata;
            end
        end
        tick();
        chk("pulse_one_cycle", {31'd0, out_fetch_valid}, 32'd0);
    endtask

    task automatic test_reset;
        rst = 1'b0; rdy = 1'b1; in_fetch_req = 1'b0; in_fetch_pc = 32'd0;
        in_mem_valid = 1'b0; in_mem_data = 32'd0; in_misbranch = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_fetch_valid}, 32'd0);
        chk("rst_instr", out_fetch_instr, 32'd0);
        chk("rst_busy", {31'd0, out_busy}, 32'd0);
        chk("rst_memreq", {31'd0, out_mem_req}, 32'd0);
        chk("rst_memaddr", out_mem_addr, 32'd0);
        model_clear();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss_and_hit;
        run_fetch(32'h0000_0100, 3, 32'h0000_0513, 1'b0);
        run_fetch(32'h0000_0100, 0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_conflict;
        run_fetch(32'h0000_0300, 2, 32'hBBBB_0001, 1'b0);
        // 0x100 was evicted by 0x300: model predicts a miss here.
        run_fetch(32'h0000_0100, 1, 32'hAAAA_0002, 1'b0);
        run_fetch(32'h0000_0300, 0, 32'hBBBB_0003, 1'b0);
    endtask

    task automatic test_misbranch;
        run_fetch(32'h0000_0200, 1, 32'h1234_5678, 1'b1);
        run_fetch(32'h0000_0200, 0, 32'h2222_0200, 1'b0);
        // Request and misbranch in the same IDLE cycle: dropped entirely.
        in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0800; in_misbranch = 1'b1;
        tick();
        in_fetch_req = 1'b0; in_misbranch = 1'b0;
        chk("drop_no_valid", {31'd0, out_fetch_valid}, 32'd0);
        chk("drop_no_memreq", {31'd0, out_mem_req}, 32'd0);
        chk("drop_not_busy", {31'd0, out_busy}, 32'd0);
    endtask

    task automatic test_back_to_back;
        in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0700;
        tick();
        in_fetch_req = 1'b0;
        chk("b2b_miss", {31'd0, out_mem_req}, 32'd1);
        in_mem_valid = 1'b1; in_mem_data = 32'h0700_0777;
        tick();
        in_mem_valid = 1'b0;
        chk("b2b_fill", out_fetch_instr, 32'h0700_0777);
        in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0700;
        tick();
        in_fetch_req = 1'b0;
        chk("b2b_hit_valid", {31'd0, out_fetch_valid}, 32'd1);
        chk("b2b_hit_instr", out_fetch_instr, 32'h0700_0777);
        chk("b2b_hit_no_req", {31'd0, out_mem_req}, 32'd0);
        ref_valid[64] = 1'b1; ref_tag[64] = 3; ref_data[64] = 32'h0700_0777;
        tick();
    endtask

    task automatic test_rdy_freeze;
        in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0400;
        tick();
        in_fetch_req = 1'b0;
        chk("frz_miss", {31'd0, out_mem_req}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_mem_valid = 1'b1; in_mem_data = 32'hBAD0_0000 + 32'(i);
            tick();
            chk("frz_req", {31'd0, out_mem_req}, 32'd1);
            chk("frz_addr", out_mem_addr, 32'h0000_0400);
            chk("frz_no_valid", {31'd0, out_fetch_valid}, 32'd0);
        end
        in_mem_valid = 1'b0; rdy = 1'b1;
        tick();
        chk("frz_still_miss", {31'd0, out_busy}, 32'd1);
        in_mem_valid = 1'b1; in_mem_data = 32'h0400_4444;
        tick();
        in_mem_valid = 1'b0;
        chk("frz_done_valid", {31'd0, out_fetch_valid}, 32'd1);
        chk("frz_done_instr", out_fetch_instr, 32'h0400_4444);
        chk("frz_done_req", {31'd0, out_mem_req}, 32'd0);
        ref_valid[0] = 1'b1; ref_tag[0] = 2; ref_data[0] = 32'h0400_4444;
        tick();
    endtask

    task automatic test_random;
        logic [31:0] pc;
        for (int n = 0; n < 200; n++) begin
            pc = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 2)) << 9)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            run_fetch(pc, int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_mid_reset;
        run_fetch(32'h0000_0100, 1, 32'h0100_0001, 1'b0);
        run_fetch(32'h0000_0100, 0, 32'h0, 1'b0);
        in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0600;
        tick();
        in_fetch_req = 1'b0;
        chk("mrst_miss", {31'd0, out_mem_req}, 32'd1);
        rst = 1'b0; in_mem_valid = 1'b1; in_mem_data = 32'h0600_0666;
        tick();
        in_mem_valid = 1'b0;
        chk("mrst_req", {31'd0, out_mem_req}, 32'd0);
        chk("mrst_busy", {31'd0, out_busy}, 32'd0);
        chk("mrst_valid", {31'd0, out_fetch_valid}, 32'd0);
        rst = 1'b1;
        model_clear();
        tick();
        run_fetch(32'h0000_0100, 2, 32'h0100_0002, 1'b0);
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_misbranch();
        test_back_to_back();
        test_rdy_freeze();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
